// File: rtl/interval_timer_arbiter.sv
// interval_timer_arbiter: round-robin share of one down-counter among NREQ timer clients
// Ports:
//   clk      - rising-edge clock
//   reset    - asynchronous active-low reset
//   req      - level request per requester, held until done or abandon
//   interval - requester i's terminal count in bits [i*WIDTH +: WIDTH]
//   grant    - one-hot owner of the counter, zero when idle
//   done     - one-cycle one-hot expiry pulse to the owner
//   busy     - high whenever the counter is owned (RUN or DONE)
//   count    - current counter value, zero when idle
module interval_timer_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] interval,
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       done,
    output logic                  busy,
    output logic [WIDTH-1:0]      count
);
    localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t        state;
    logic [LW-1:0] last;
    logic [LW-1:0] win;
    logic [LW-1:0] cand;
    // Walk the ring from farthest to nearest so the nearest set bit after last wins.
    always_comb begin
        win  = last;
        cand = last;
        for (int k = NREQ; k >= 1; k--) begin
            cand = LW'((int'(last) + k) % NREQ);
            if (req[cand]) win = cand;
        end
    end
    // last doubles as the owner index while RUN or DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            grant <= '0;
            done  <= '0;
            busy  <= 1'b0;
            count <= '0;
            last  <= LW'(NREQ - 1);
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        state <= RUN;
                        grant <= NREQ'(1) << win;
                        busy  <= 1'b1;
                        count <= interval[win*WIDTH +: WIDTH];
                        last  <= win;
                    end
                end
                RUN: begin
                    if (!req[last]) begin
                        state <= IDLE;
                        grant <= '0;
                        busy  <= 1'b0;
                        count <= '0;
                    end else if (count == '0) begin
                        state <= DONE;
                        done  <= grant;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                    count <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_interval_timer_arbiter.sv
// tb_interval_timer_arbiter: directed and random checks against a transaction-level model
module tb_interval_timer_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 16;
    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*WIDTH-1:0] interval = '0;
    logic [NREQ-1:0]       grant;
    logic [NREQ-1:0]       done;
    logic                  busy;
    logic [WIDTH-1:0]      count;
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int m_own = -1;
    int m_dn = -1;
    int m_cnt = 0;
    int m_last = NREQ - 1;
    logic [NREQ-1:0]  eg;
    logic [NREQ-1:0]  ed;
    logic [WIDTH-1:0] ec;

    interval_timer_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .req(req), .interval(interval),
        .grant(grant), .done(done), .busy(busy), .count(count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    // Reference: one owner at a time, tracked as an index plus remaining count;
    // m_dn marks the single cycle in which the owner is being told it expired.
    always begin
        @(posedge clk or negedge reset);
        if (!reset) begin
            m_own = -1; m_dn = -1; m_cnt = 0; m_last = NREQ - 1;
        end else if (m_dn >= 0) begin
            m_dn = -1;
        end else if (m_own >= 0) begin
            if (!req[m_own]) m_own = -1;
            else if (m_cnt == 0) begin m_dn = m_own; m_own = -1; end
            else m_cnt = m_cnt - 1;
        end else if (req != 0) begin
            for (int k = 1; k <= NREQ && m_own < 0; k++)
                if (req[(m_last + k) % NREQ]) m_own = (m_last + k) % NREQ;
            m_cnt = int'(interval[m_own*WIDTH +: WIDTH]);
            m_last = m_own;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            eg = (m_own >= 0) ? NREQ'(1 << m_own) : (m_dn >= 0) ? NREQ'(1 << m_dn) : '0;
            ed = (m_dn >= 0) ? NREQ'(1 << m_dn) : '0;
            ec = (m_own >= 0) ? WIDTH'(m_cnt) : '0;
            chk("outs", 32'({grant, done, busy, count}), 32'({eg, ed, (m_own >= 0 || m_dn >= 0), ec}));
        end
    end

    // what: 0 grant!=0, 1 done!=0, 2 count==val
    task automatic wait_until(input string tag, input int what, input int val, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((what == 0 && grant != 0) || (what == 1 && done != 0) || (what == 2 && int'(count) == val)) begin
                at = cyc;
                return;
            end
        end
        chk(tag, 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk) reset = 1'b0;
        @(negedge clk) reset = 1'b1;
    endtask

    initial begin
        int tg, td, n;
        int rr[5];
        #1;
        chk("rst", 32'({grant, done, busy, count}), 32'd0);
        @(negedge clk);
        @(negedge clk) reset = 1'b1;
        // single request, interval 5
        interval[0 +: WIDTH] = 16'd5;
        req = 4'b0001;
        wait_until("to_g0", 0, 0, 10, tg);
        chk("g0", 32'(grant), 32'h1);
        chk("c0", 32'(count), 32'd5);
        wait_until("to_d0", 1, 0, 20, td);
        chk("lat5", 32'(td - tg), 32'd6);
        chk("d0", 32'(done), 32'h1);
        req = '0;
        @(negedge clk);
        chk("gclr", 32'({grant, done, busy}), 32'd0);
        // zero interval
        @(negedge clk);
        interval[WIDTH +: WIDTH] = 16'd0;
        req = 4'b0010;
        wait_until("to_g1", 0, 0, 10, tg);
        n = 1;
        for (int i = 0; i < 10 && busy; i++) begin
            @(negedge clk);
            if (done != 0) req = '0;
            if (busy) n++;
        end
        chk("busy2", 32'(n), 32'd2);
        // round robin from a fresh pointer
        do_reset();
        for (int i = 0; i < NREQ; i++) interval[i*WIDTH +: WIDTH] = 16'd2;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_until("to_rr", 0, 0, 20, rr[k]);
            chk("rrg", 32'(grant), 32'(1 << (k % NREQ)));
            wait_until("to_rrd", 1, 0, 20, td);
            chk("rrlat", 32'(td - rr[k]), 32'd3);
            if (k > 0) chk("rrgap", 32'(rr[k] - rr[k-1]), 32'd5);
            @(negedge clk);
        end
        req = '0;
        repeat (8) @(negedge clk);
        // abandon at count 10
        interval[WIDTH +: WIDTH] = 16'd20;
        req = 4'b0010;
        wait_until("to_ab", 2, 10, 40, tg);
        req = '0;
        @(negedge clk);
        chk("abn", 32'({grant, done, busy, count}), 32'd0);
        req = 4'b0110;
        wait_until("to_abg", 0, 0, 10, tg);
        chk("abng", 32'(grant), 32'h4);
        req = '0;
        repeat (4) @(negedge clk);
        // asynchronous reset mid-run
        interval[0 +: WIDTH] = 16'd12;
        req = 4'b0001;
        wait_until("to_ar", 2, 7, 40, tg);
        #2 reset = 1'b0;
        #1 chk("arst", 32'({grant, done, busy, count}), 32'd0);
        req = 4'b1001;
        @(negedge clk) reset = 1'b1;
        wait_until("to_arg", 0, 0, 10, tg);
        chk("arg", 32'(grant), 32'h1);
        req = '0;
        repeat (4) @(negedge clk);
        // interval change during RUN is ignored
        interval[0 +: WIDTH] = 16'd6;
        req = 4'b0001;
        wait_until("to_ic", 0, 0, 10, tg);
        @(negedge clk) interval[0 +: WIDTH] = 16'd3;
        wait_until("to_icd", 1, 0, 30, td);
        chk("iclat", 32'(td - tg), 32'd7);
        req = '0;
        repeat (3) @(negedge clk);
        // drop at count==0 beats expiry
        interval[0 +: WIDTH] = 16'd4;
        req = 4'b0001;
        wait_until("to_z", 0, 0, 10, tg);
        wait_until("to_z0", 2, 0, 10, tg);
        req = '0;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done != 0) n++;
        end
        chk("nodone", 32'(n), 32'd0);
        // full-width interval, no wrap
        interval[0 +: WIDTH] = 16'hFFFF;
        req = 4'b0001;
        wait_until("to_f", 0, 0, 10, tg);
        wait_until("to_fd", 1, 0, 70000, td);
        chk("latffff", 32'(td - tg), 32'd65536);
        req = '0;
        repeat (3) @(negedge clk);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            for (int b = 0; b < NREQ; b++) begin
                if ($urandom_range(0, 11) == 0) req[b] = ~req[b];
                if ($urandom_range(0, 7) == 0) interval[b*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 999) == 0) begin
                #1 reset = 1'b0;
                #2 reset = 1'b1;
            end
        end
        req = '0;
        repeat (20) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
